instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes instruction requests into 32-bit machine words for the single-cycle CPU's supported subset: addu, subu, or, ori, lui, lw, sw, beq, j, jal, jr, nop and the custom bnezalc. Each encoded word is written sequentially into the instruction memory's load port. A small FSM appends a self-loop terminator on request, and a counter tracks the word address and PC. The block sits in the test and boot harness in front of IM; it is the encoding counterpart of the CPU's decode controller.

## Interface
- DEPTH, 1024: IM capacity in words. One slot is always reserved for the terminator.
- ADDR_W, 10: word-address width; DEPTH ≤ 2^ADDR_W.
- BASE, 32'h0000_3000: byte PC of word 0.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous restart to word 0; lower priority than reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when in_valid=1
- kind  in  4  instruction kind code (package enum)
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate / branch offset (words, two's complement)
- target  in  26  jump target field
- finish  in  1  request terminator write
- im_we  out  1  IM write strobe
- im_addr  out  ADDR_W  IM word address
- im_wdata  out  32  encoded word
- pc  out  32  BASE + 4*count; the PC of the next word to be written
- count  out  ADDR_W+1  number of words written
- full  out  1  count ≥ DEPTH-1
- err  out  1  one-cycle pulse on an illegal kind
- done  out  1  state == DONE

## Operation
- FSM states:
  - RUN: accepts requests.
  - TERM: writes the terminator.
  - DONE: idle until clear or reset.
- in_ready = (state==RUN) && !full. This is combinational from registered state only.
- Encodings (op | rs | rt | rd | shamt | func). Fields not listed are forced to 0.
  - addu: 000000, rs, rt, rd, 0, 100001
  - subu: 000000, rs, rt, rd, 0, 100011
  - or: 000000, rs, rt, rd, 0, 100101
  - jr: 000000, rs, 0, 0, 0, 001000
  - nop: 32'h0
  - ori: 001101, rs, rt, imm
  - lui: 001111, 0, rt, imm
  - lw: 100011, rs, rt, imm
  - sw: 101011, rs, rt, imm
  - beq: 000100, rs, rt, imm
  - j: 000010, target
  - jal: 000011, target
  - bnezalc: 000001, rs, rt=10011 (input rt ignored), imm
- Illegal kind on an accepted handshake:
  - no write; count unchanged
  - err=1 for the next cycle only
- Terminator: beq $0,$0,-1 = 32'h1000_FFFF.
- finish sampled in RUN moves the FSM to TERM.
- TERM: writes the terminator at im_addr=count, increments count, then moves to DONE.
- finish in TERM/DONE is ignored. in_valid in TERM/DONE is not accepted.
- clear in any state: state→RUN, count→0, im_we→0, err→0. im_addr/im_wdata hold.

## Timing
- Handshake in cycle N produces, in cycle N+1:
  - im_we=1, im_addr=count(N), im_wdata=encoded word
  - count=count(N)+1
- Latency is one cycle. Throughput is one word per cycle.
- im_we is high for exactly one cycle per write.
- in_valid, finish and the handshake in the same RUN cycle:
  - the instruction is written in N+1
  - the terminator is written in N+2
  - done=1 from N+3
- finish alone in cycle N: terminator written in N+2 (N+1 is TERM), done=1 from N+3.
- Full: once count reaches DEPTH-1, in_ready=0. finish still writes the terminator into slot DEPTH-1.
- Reset values: state=RUN, count=0, im_we=0, im_addr=0, im_wdata=0, err=0. Derived values: pc=BASE, full=0, done=0, in_ready=1.
- Reset or clear mid-TERM aborts the terminator write. No partial write is emitted.
- count never wraps. Maximum value is DEPTH.

## Structure
- Package instr_pkg holds:
  - the kind enum: NOP=0, ADDU, SUBU, OR, ORI, LUI, LW, SW, BEQ, J, JAL, JR, BNEZALC; codes 13–15 are illegal
  - the opcode and funct constants
  - the BNEZALC_RT constant (5'b10011)
  - TERM_WORD
  - the FSM state enum
- One sub-module, instr_field_pack: purely combinational mapping from kind plus fields to {word, legal}. The top module holds the FSM, counter and output registers.

## Test plan
- addu rs=1 rt=2 rd=3 accepted at reset+1 → next cycle: im_we=1, addr=0, wdata=32'h0022_1821, pc=32'h3004.
- Back-to-back stream, one per cycle, of four requests → addresses 0–3, no gaps, count=4. The four requests and expected words:
  - ori rt=1 imm=16'h1234 → 32'h3401_1234
  - lui rt=2 imm=16'hABCD with rs=7 → 32'h3C02_ABCD
  - lw rs=5 rt=4 imm=8 → 32'h8CA4_0008
  - jal target=26'hC00 → 32'h0C00_0C00
- bnezalc rs=7 rt=0 imm=4 → 32'h04F3_0004. kind=14 → err pulse for 1 cycle, no im_we, count unchanged.
- DEPTH=4: push 5 requests. Expected response:
  - 3 requests accepted, then in_ready=0 and full=1
  - finish → 32'h1000_FFFF written at addr 3, done=1, count=4
- in_valid (nop) and finish in the same cycle → nop at N+1, terminator at N+2, done=1 at N+3. Then clear → count=0, in_ready=1.
- reset asserted during TERM → no terminator write; all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction encoder.
// Kind codes, MIPS opcode/funct values and the FSM state enum.
package instr_pkg;

  typedef enum logic [3:0] {
    K_NOP     = 4'd0,
    K_ADDU    = 4'd1,
    K_SUBU    = 4'd2,
    K_OR      = 4'd3,
    K_ORI     = 4'd4,
    K_LUI     = 4'd5,
    K_LW      = 4'd6,
    K_SW      = 4'd7,
    K_BEQ     = 4'd8,
    K_J       = 4'd9,
    K_JAL     = 4'd10,
    K_JR      = 4'd11,
    K_BNEZALC = 4'd12
  } kind_e;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_TERM = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [4:0]  BNEZALC_RT = 5'b10011;
  // beq $0,$0,-1: the CPU spins here once the program ends
  localparam logic [31:0] TERM_WORD  = 32'h1000_FFFF;

  function automatic logic [31:0] enc_r(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [5:0]  op,
    input logic [25:0] tg
  );
    return {op, tg};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: kind plus register/immediate fields
// to a 32-bit machine word and a legal flag.
module instr_field_pack
  import instr_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (kind)
      K_NOP:     word = '0;
      K_ADDU:    word = enc_r(rs, rt, rd, FN_ADDU);
      K_SUBU:    word = enc_r(rs, rt, rd, FN_SUBU);
      K_OR:      word = enc_r(rs, rt, rd, FN_OR);
      K_JR:      word = enc_r(rs, 5'd0, 5'd0, FN_JR);
      K_ORI:     word = enc_i(OP_ORI, rs, rt, imm);
      K_LUI:     word = enc_i(OP_LUI, 5'd0, rt, imm);
      K_LW:      word = enc_i(OP_LW, rs, rt, imm);
      K_SW:      word = enc_i(OP_SW, rs, rt, imm);
      K_BEQ:     word = enc_i(OP_BEQ, rs, rt, imm);
      K_J:       word = enc_j(OP_J, target);
      K_JAL:     word = enc_j(OP_JAL, target);
      K_BNEZALC: word = enc_i(OP_REGIMM, rs, BNEZALC_RT, imm);
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instructions into the IM load port and
// appends a self-loop terminator on request.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int          DEPTH  = 1024,
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              finish,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [31:0]       pc,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              done
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CAP  = (ADDR_W+1)'(DEPTH);

  state_e              r_state;
  state_e              w_next;
  logic                r_tw;
  logic [ADDR_W:0]     r_count;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;

  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_full;
  logic                w_hs;
  logic                w_term_wr;

  instr_field_pack u_pack (
    .kind   (kind),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm),
    .target (target),
    .word   (w_word),
    .legal  (w_legal)
  );

  assign w_full    = r_count >= LAST;
  assign in_ready  = (r_state == S_RUN) && !w_full;
  assign w_hs      = in_valid && in_ready;
  // r_tw marks the terminator as issued; TERM lasts until it is visible
  assign w_term_wr = (r_state == S_TERM) && !r_tw && (r_count < CAP);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:   if (finish) w_next = S_TERM;
      S_TERM:  if (r_tw) w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_tw    <= 1'b0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_state <= S_RUN;
      r_tw    <= 1'b0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tw    <= (r_state == S_TERM);
      r_we    <= 1'b0;
      r_err   <= w_hs && !w_legal;
      if (w_hs && w_legal) begin
        r_we    <= 1'b1;
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_word;
        r_count <= r_count + 1'b1;
      end else if (w_term_wr) begin
        r_we    <= 1'b1;
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= TERM_WORD;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign im_we    = r_we;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign count    = r_count;
  assign full     = w_full;
  assign err      = r_err;
  assign done     = (r_state == S_DONE);
  assign pc       = BASE + (32'(r_count) << 2);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus
// a randomized stream against an arithmetic encoding model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, finish;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        in_ready, im_we, full, err, done;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata, pc;
  logic [10:0] count;

  logic        reset1, clear1, valid1, finish1;
  logic        ready1, we1, full1, err1, done1;
  logic [1:0]  addr1;
  logic [31:0] wdata1, pc1;
  logic [2:0]  count1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_encoder u0 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target), .finish(finish),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .pc(pc), .count(count), .full(full), .err(err), .done(done)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(2)) u1 (
    .clk(clk), .reset(reset1), .clear(clear1),
    .in_valid(valid1), .in_ready(ready1),
    .kind(kind), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target), .finish(finish1),
    .im_we(we1), .im_addr(addr1), .im_wdata(wdata1),
    .pc(pc1), .count(count1), .full(full1), .err(err1), .done(done1)
  );

  // Reference encoder built from the ISA field layout with plain arithmetic
  function automatic logic [31:0] ref_enc(
    input int k, input int s, input int t, input int d,
    input int im, input int tg, output bit ok
  );
    logic [31:0] w;
    ok = 1'b1;
    w = 32'd0;
    case (k)
      0:  w = 32'd0;
      1:  w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'd33;
      2:  w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'd35;
      3:  w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'd37;
      4:  w = (32'd13 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
      5:  w = (32'd15 << 26) | (32'(t) << 16) | 32'(im);
      6:  w = (32'd35 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
      7:  w = (32'd43 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
      8:  w = (32'd4 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
      9:  w = (32'd2 << 26) | 32'(tg);
      10: w = (32'd3 << 26) | 32'(tg);
      11: w = (32'(s) << 21) | 32'd8;
      12: w = (32'd1 << 26) | (32'(s) << 21) | (32'd19 << 16) | 32'(im);
      default: ok = 1'b0;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; finish = 0; clear = 0;
    kind = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; reset1 = 1;
    clear1 = 0; valid1 = 0; finish1 = 0;
    tick(); tick();
    reset = 0; reset1 = 0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (im_we !== 1'b0) $display("FAIL rst_we got %b want 0", im_we); else n_pass++;
    n_total++; if (im_addr !== 10'd0) $display("FAIL rst_addr got %h want 0", im_addr); else n_pass++;
    n_total++; if (im_wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", im_wdata); else n_pass++;
    n_total++; if (count !== 11'd0) $display("FAIL rst_count got %0d want 0", count); else n_pass++;
    n_total++; if (pc !== 32'h3000) $display("FAIL rst_pc got %h want 3000", pc); else n_pass++;
    n_total++; if ({full, err, done} !== 3'b000) $display("FAIL rst_flags got %b want 000", {full, err, done}); else n_pass++;
  endtask

  task automatic test_addu();
    do_reset();
    kind = 1; rs = 1; rt = 2; rd = 3; in_valid = 1;
    tick();
    in_valid = 0;
    n_total++; if (im_we !== 1'b1) $display("FAIL addu_we got %b want 1", im_we); else n_pass++;
    n_total++; if (im_addr !== 10'd0) $display("FAIL addu_addr got %h want 0", im_addr); else n_pass++;
    n_total++; if (im_wdata !== 32'h0022_1821) $display("FAIL addu_word got %h want 00221821", im_wdata); else n_pass++;
    n_total++; if (pc !== 32'h3004) $display("FAIL addu_pc got %h want 3004", pc); else n_pass++;
    tick();
    n_total++; if (im_we !== 1'b0) $display("FAIL addu_we_pulse got %b want 0", im_we); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  k_t[4]  = '{4'd4, 4'd5, 4'd6, 4'd10};
    logic [4:0]  rs_t[4] = '{5'd0, 5'd7, 5'd5, 5'd0};
    logic [4:0]  rt_t[4] = '{5'd1, 5'd2, 5'd4, 5'd0};
    logic [15:0] im_t[4] = '{16'h1234, 16'hABCD, 16'h0008, 16'h0};
    logic [25:0] tg_t[4] = '{26'h0, 26'h0, 26'h0, 26'hC00};
    logic [31:0] w_t[4]  = '{32'h3401_1234, 32'h3C02_ABCD, 32'h8CA4_0008, 32'h0C00_0C00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      kind = k_t[i]; rs = rs_t[i]; rt = rt_t[i]; rd = 0;
      imm = im_t[i]; target = tg_t[i]; in_valid = 1;
      tick();
      n_total++; if (im_we !== 1'b1 || im_addr !== 10'(i))
        $display("FAIL b2b_addr%0d got we=%b addr=%0d want we=1 addr=%0d", i, im_we, im_addr, i);
      else n_pass++;
      n_total++; if (im_wdata !== w_t[i])
        $display("FAIL b2b_word%0d got %h want %h", i, im_wdata, w_t[i]);
      else n_pass++;
    end
    in_valid = 0;
    n_total++; if (count !== 11'd4) $display("FAIL b2b_count got %0d want 4", count); else n_pass++;
  endtask

  task automatic test_bnezalc_err();
    do_reset();
    kind = 12; rs = 7; rt = 0; imm = 4; in_valid = 1;
    tick();
    n_total++; if (im_wdata !== 32'h04F3_0004 || im_we !== 1'b1)
      $display("FAIL bnezalc got we=%b word=%h want we=1 word=04f30004", im_we, im_wdata);
    else n_pass++;
    kind = 14;
    tick();
    in_valid = 0;
    n_total++; if (err !== 1'b1) $display("FAIL illegal_err got %b want 1", err); else n_pass++;
    n_total++; if (im_we !== 1'b0) $display("FAIL illegal_we got %b want 0", im_we); else n_pass++;
    n_total++; if (count !== 11'd1) $display("FAIL illegal_count got %0d want 1", count); else n_pass++;
    tick();
    n_total++; if (err !== 1'b0) $display("FAIL illegal_err_pulse got %b want 0", err); else n_pass++;
  endtask

  task automatic test_random();
    int          m_count;
    bit          e_we, e_err, ok, v;
    logic [31:0] e_word, w;
    int          e_addr, k, s, t, d, im, tg;
    do_reset();
    m_count = 0; e_we = 0; e_err = 0; e_word = 0; e_addr = 0;
    for (int i = 0; i < 300; i++) begin
      n_total++; if (im_we !== e_we || err !== e_err || count !== 11'(m_count))
        $display("FAIL rnd_ctl%0d got we=%b err=%b cnt=%0d want we=%b err=%b cnt=%0d",
                 i, im_we, err, count, e_we, e_err, m_count);
      else n_pass++;
      if (e_we) begin
        n_total++; if (im_addr !== 10'(e_addr) || im_wdata !== e_word)
          $display("FAIL rnd_word%0d got %0d:%h want %0d:%h", i, im_addr, im_wdata, e_addr, e_word);
        else n_pass++;
      end
      v  = ($urandom % 4) != 0;
      k  = int'($urandom % 16);
      s  = int'($urandom % 32);
      t  = int'($urandom % 32);
      d  = int'($urandom % 32);
      im = int'($urandom % 65536);
      tg = int'($urandom % (1 << 26));
      in_valid = v; kind = 4'(k); rs = 5'(s); rt = 5'(t); rd = 5'(d);
      imm = 16'(im); target = 26'(tg);
      w = ref_enc(k, s, t, d, im, tg, ok);
      e_we   = v && ok;
      e_err  = v && !ok;
      e_addr = m_count;
      e_word = w;
      if (e_we) m_count++;
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_finish_same_cycle();
    do_reset();
    kind = 0; in_valid = 1; finish = 1;
    tick();
    in_valid = 0; finish = 0;
    n_total++; if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'd0)
      $display("FAIL fin_nop got we=%b addr=%0d word=%h want 1/0/0", im_we, im_addr, im_wdata);
    else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL fin_ready got %b want 0", in_ready); else n_pass++;
    tick();
    n_total++; if (im_we !== 1'b1 || im_addr !== 10'd1 || im_wdata !== 32'h1000_FFFF)
      $display("FAIL fin_term got we=%b addr=%0d word=%h want 1/1/1000ffff", im_we, im_addr, im_wdata);
    else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL fin_done_early got %b want 0", done); else n_pass++;
    tick();
    n_total++; if (done !== 1'b1 || count !== 11'd2 || im_we !== 1'b0)
      $display("FAIL fin_done got done=%b cnt=%0d we=%b want 1/2/0", done, count, im_we);
    else n_pass++;
    in_valid = 1; finish = 1;
    tick();
    in_valid = 0; finish = 0;
    n_total++; if (im_we !== 1'b0 || count !== 11'd2)
      $display("FAIL done_ignore got we=%b cnt=%0d want 0/2", im_we, count);
    else n_pass++;
    clear = 1;
    tick();
    clear = 0;
    n_total++; if (count !== 11'd0 || in_ready !== 1'b1 || done !== 1'b0 || pc !== 32'h3000)
      $display("FAIL clear got cnt=%0d rdy=%b done=%b pc=%h want 0/1/0/3000", count, in_ready, done, pc);
    else n_pass++;
  endtask

  task automatic test_reset_in_term();
    do_reset();
    kind = 1; rs = 1; rt = 2; rd = 3; in_valid = 1;
    tick();
    in_valid = 0; finish = 1;
    tick();
    finish = 0; reset = 1;
    tick();
    reset = 0;
    n_total++; if (im_we !== 1'b0 || im_addr !== 10'd0 || im_wdata !== 32'd0)
      $display("FAIL rterm_out got we=%b addr=%0d word=%h want 0/0/0", im_we, im_addr, im_wdata);
    else n_pass++;
    n_total++; if (count !== 11'd0 || done !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0)
      $display("FAIL rterm_state got cnt=%0d done=%b rdy=%b err=%b want 0/0/1/0", count, done, in_ready, err);
    else n_pass++;
    tick();
    n_total++; if (im_we !== 1'b0) $display("FAIL rterm_late_we got %b want 0", im_we); else n_pass++;
  endtask

  task automatic test_full();
    int acc;
    reset1 = 1;
    tick();
    reset1 = 0;
    kind = 1; rs = 4; rt = 5; rd = 6;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      valid1 = 1;
      if (ready1 === 1'b1) acc++;
      tick();
    end
    valid1 = 0;
    n_total++; if (acc !== 3) $display("FAIL full_accepted got %0d want 3", acc); else n_pass++;
    n_total++; if (ready1 !== 1'b0 || full1 !== 1'b1 || count1 !== 3'd3)
      $display("FAIL full_flags got rdy=%b full=%b cnt=%0d want 0/1/3", ready1, full1, count1);
    else n_pass++;
    finish1 = 1;
    tick();
    finish1 = 0;
    n_total++; if (we1 !== 1'b0) $display("FAIL full_term_wait got %b want 0", we1); else n_pass++;
    tick();
    n_total++; if (we1 !== 1'b1 || addr1 !== 2'd3 || wdata1 !== 32'h1000_FFFF)
      $display("FAIL full_term got we=%b addr=%0d word=%h want 1/3/1000ffff", we1, addr1, wdata1);
    else n_pass++;
    tick();
    n_total++; if (done1 !== 1'b1 || count1 !== 3'd4 || pc1 !== 32'h3010)
      $display("FAIL full_done got done=%b cnt=%0d pc=%h want 1/4/3010", done1, count1, pc1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_back_to_back();
    test_bnezalc_err();
    test_random();
    test_finish_same_cycle();
    test_reset_in_term();
    test_full();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
